// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle control path.
// Holds FSM state codes, opcodes, ALU/writeback selects and the control strobe bundle.
package riscv_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_ifetch;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
  } ctrl_t;

  // LUI needs no ALU work, so it skips EXEC and goes straight to writeback.
  function automatic state_t decode_next(input logic [6:0] opc);
    state_t nxt;
    case (opc)
      OPC_LUI:                                             nxt = ST_WB;
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_BRANCH: nxt = ST_EXEC;
      default:                                             nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] wb_sel_for(input logic [6:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_LOAD: sel = WB_MEM;
      OPC_LUI:  sel = WB_IMM;
      default:  sel = WB_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from funct3 and ALU compare flags; purely combinational.
// Unsigned compares (BLTU/BGEU) and reserved encodings resolve as not taken.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; Mealy outputs, 3-5 cycles per instruction.
// Memory stalls hold mem_req and its qualifiers until mem_ready; a stuck port traps after TIMEOUT_CYCLES.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_ifetch,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 alu_src_imm,
  output logic [1:0]           alu_op,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned      TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t                 state_q, state_d;
  logic [TO_W-1:0]        wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  ctrl_t                  ctl;
  ctrl_t                  ctl_o;
  logic                   retire;
  logic                   br_taken;
  logic                   mem_wait;
  logic [TO_W-1:0]        wait_inc;
  logic                   timeout_hit;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .taken    (br_taken)
  );

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    retire  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_ifetch = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = 1'b0;
          state_d      = ST_DECODE;
        end
      end

      ST_DECODE: state_d = decode_next(opcode);

      ST_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: begin
            ctl.alu_src_imm = 1'b1;
            ctl.alu_op      = ALU_ADD;
            state_d         = ST_MEM;
          end
          OPC_OP_IMM: begin
            ctl.alu_src_imm = 1'b1;
            ctl.alu_op      = ALU_FUNCT;
            state_d         = ST_WB;
          end
          OPC_OP: begin
            ctl.alu_src_imm = 1'b0;
            ctl.alu_op      = ALU_FUNCT;
            state_d         = ST_WB;
          end
          OPC_BRANCH: begin
            ctl.alu_op   = ALU_SUB;
            ctl.pc_write = br_taken;
            ctl.pc_src   = br_taken;
            retire       = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_ifetch = 1'b0;
        ctl.mem_we     = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = wb_sel_for(opcode);
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_TRAP: ctl.trap = 1'b1;

      default: state_d = ST_TRAP;
    endcase

    // Only stalled cycles count, so any cycle without a pending request restarts the wait window.
    mem_wait    = ctl.mem_req && !mem_ready;
    wait_inc    = wait_q + TO_W'(1);
    timeout_hit = TO_EN && mem_wait && (wait_inc == TO_LIMIT);
    wait_d      = (TO_EN && mem_wait) ? wait_inc : '0;
    if (timeout_hit) begin
      state_d = ST_TRAP;
    end

    instret_d = instret_q + INSTRET_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Reset gates every strobe in the same cycle, aborting any in-flight transfer.
  assign ctl_o       = reset ? '0 : ctl;
  assign mem_req     = ctl_o.mem_req;
  assign mem_we      = ctl_o.mem_we;
  assign mem_ifetch  = ctl_o.mem_ifetch;
  assign ir_write    = ctl_o.ir_write;
  assign pc_write    = ctl_o.pc_write;
  assign pc_src      = ctl_o.pc_src;
  assign reg_write   = ctl_o.reg_write;
  assign alu_src_imm = ctl_o.alu_src_imm;
  assign alu_op      = ctl_o.alu_op;
  assign wb_sel      = ctl_o.wb_sel;
  assign trap        = ctl_o.trap;
  assign instret     = instret_q;

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_ready && state_d != ST_TRAP) |=>
      (mem_req && mem_ifetch == $past(mem_ifetch) && mem_we == $past(mem_we)));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, directed multi-cycle sequences and a random run
// compared against an instruction-level reference model, for timeouts of 255 and 4.
module tb_multicycle_ctrl;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_OPI    = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_ILL    = 7'b1110011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_ifetch;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
  } outs_t;

  typedef struct {
    bit         r;
    logic [6:0] op;
    logic [2:0] f3;
    bit         z;
    bit         lt;
    bit         rdy;
    outs_t      eo;
    int         ei;
  } vec_t;

  localparam outs_t O0 = '0;
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEM = 3, PH_WB = 4, PH_TRAP = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = T_OPI;
  logic [2:0]  funct3 = 3'd0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        mem_ready = 1'b0;

  logic a_req, a_we, a_if, a_irw, a_pcw, a_pcs, a_rw, a_imm, a_trap;
  logic b_req, b_we, b_if, b_irw, b_pcw, b_pcs, b_rw, b_imm, b_trap;
  logic [1:0]  a_aop, a_wbs, b_aop, b_wbs;
  logic [31:0] a_inst, b_inst;
  outs_t       got0, got1;

  int n_vec = 0;
  int n_bad = 0;

  int       m_ph  [2];
  int       m_w   [2];
  bit [31:0] m_ret [2];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .mem_ready(mem_ready), .mem_req(a_req), .mem_we(a_we),
    .mem_ifetch(a_if), .ir_write(a_irw), .pc_write(a_pcw), .pc_src(a_pcs),
    .reg_write(a_rw), .alu_src_imm(a_imm), .alu_op(a_aop), .wb_sel(a_wbs),
    .trap(a_trap), .instret(a_inst)
  );

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .INSTRET_W(32)) dut_to (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .mem_ready(mem_ready), .mem_req(b_req), .mem_we(b_we),
    .mem_ifetch(b_if), .ir_write(b_irw), .pc_write(b_pcw), .pc_src(b_pcs),
    .reg_write(b_rw), .alu_src_imm(b_imm), .alu_op(b_aop), .wb_sel(b_wbs),
    .trap(b_trap), .instret(b_inst)
  );

  assign got0 = {a_req, a_we, a_if, a_irw, a_pcw, a_pcs, a_rw, a_imm, a_aop, a_wbs, a_trap};
  assign got1 = {b_req, b_we, b_if, b_irw, b_pcw, b_pcs, b_rw, b_imm, b_aop, b_wbs, b_trap};

  function automatic outs_t o_fetch(input bit done);
    outs_t o = '0;
    o.mem_req = 1'b1; o.mem_ifetch = 1'b1; o.ir_write = done; o.pc_write = done;
    return o;
  endfunction

  function automatic outs_t o_exec(input bit imm, input logic [1:0] aop, input bit pcw);
    outs_t o = '0;
    o.alu_src_imm = imm; o.alu_op = aop; o.pc_write = pcw; o.pc_src = pcw;
    return o;
  endfunction

  function automatic outs_t o_mem(input bit we);
    outs_t o = '0;
    o.mem_req = 1'b1; o.mem_we = we;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] sel);
    outs_t o = '0;
    o.reg_write = 1'b1; o.wb_sel = sel;
    return o;
  endfunction

  function automatic outs_t o_trap();
    outs_t o = '0;
    o.trap = 1'b1;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [6:0] op, input logic [2:0] f3,
                       input bit z, input bit lt, input bit rdy);
    @(negedge clk);
    reset = r; opcode = op; funct3 = f3; alu_zero = z; alu_lt = lt; mem_ready = rdy;
    #1;
  endtask

  task automatic step(input int k, input string nm, input bit r, input logic [6:0] op,
                      input logic [2:0] f3, input bit z, input bit lt, input bit rdy,
                      input outs_t e, input int ei);
    drive(r, op, f3, z, lt, rdy);
    chk({nm, " ctl"}, (k == 0) ? 32'(got0) : 32'(got1), 32'(e));
    if (ei >= 0) chk({nm, " instret"}, (k == 0) ? a_inst : b_inst, ei);
  endtask

  // Instruction-level model: a memory access either completes or burns one wait slot.
  task automatic mem_access(input int k, input int to, input int next_ph, output bit done);
    done = 1'b0;
    if (mem_ready) begin
      done = 1'b1;
      m_ph[k] = next_ph;
      m_w[k] = 0;
    end else begin
      m_w[k]++;
      if (to != 0 && m_w[k] == to) m_ph[k] = PH_TRAP;
    end
  endtask

  task automatic retire(input int k);
    m_ret[k] = m_ret[k] + 1;
    m_ph[k] = PH_FETCH;
    m_w[k] = 0;
  endtask

  task automatic model_cycle(input int k, input int to, output outs_t e, output bit fetched);
    bit done, taken;
    e = '0;
    fetched = 1'b0;
    if (reset) begin
      m_ph[k] = PH_FETCH; m_w[k] = 0; m_ret[k] = 0;
      return;
    end
    case (m_ph[k])
      PH_FETCH: begin
        mem_access(k, to, PH_DECODE, done);
        e = o_fetch(done);
        fetched = done;
      end
      PH_DECODE: begin
        if (opcode == T_LUI) m_ph[k] = PH_WB;
        else if (opcode inside {T_LOAD, T_STORE, T_OPI, T_OP, T_BRANCH}) m_ph[k] = PH_EXEC;
        else m_ph[k] = PH_TRAP;
      end
      PH_EXEC: begin
        if (opcode == T_LOAD || opcode == T_STORE) begin
          e = o_exec(1'b1, 2'b00, 1'b0); m_ph[k] = PH_MEM; m_w[k] = 0;
        end else if (opcode == T_OPI) begin
          e = o_exec(1'b1, 2'b10, 1'b0); m_ph[k] = PH_WB;
        end else if (opcode == T_OP) begin
          e = o_exec(1'b0, 2'b10, 1'b0); m_ph[k] = PH_WB;
        end else begin
          case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            default: taken = 1'b0;
          endcase
          e = o_exec(1'b0, 2'b01, taken);
          retire(k);
        end
      end
      PH_MEM: begin
        e = o_mem(opcode == T_STORE);
        mem_access(k, to, PH_WB, done);
        if (done && opcode == T_STORE) retire(k);
      end
      PH_WB: begin
        e = o_wb((opcode == T_LOAD) ? 2'b01 : (opcode == T_LUI) ? 2'b10 : 2'b00);
        retire(k);
      end
      default: e = o_trap();
    endcase
  endtask

  initial begin
    vec_t       tbl [13];
    logic [6:0] legal [6];
    outs_t      e;
    bit         f, fdummy, need_op, r;

    // OP-IMM, then BEQ taken, then BNE not taken with alu_zero = 1
    tbl[0]  = '{1'b1, T_OPI,    3'd0, 1'b0, 1'b0, 1'b1, O0,                        -1};
    tbl[1]  = '{1'b0, T_OPI,    3'd0, 1'b0, 1'b0, 1'b1, o_fetch(1'b1),              0};
    tbl[2]  = '{1'b0, T_OPI,    3'd0, 1'b0, 1'b0, 1'b1, O0,                         0};
    tbl[3]  = '{1'b0, T_OPI,    3'd0, 1'b0, 1'b0, 1'b1, o_exec(1'b1, 2'b10, 1'b0),  0};
    tbl[4]  = '{1'b0, T_OPI,    3'd0, 1'b0, 1'b0, 1'b1, o_wb(2'b00),                0};
    tbl[5]  = '{1'b0, T_BRANCH, 3'd0, 1'b1, 1'b0, 1'b1, o_fetch(1'b1),              1};
    tbl[6]  = '{1'b0, T_BRANCH, 3'd0, 1'b1, 1'b0, 1'b1, O0,                         1};
    tbl[7]  = '{1'b0, T_BRANCH, 3'd0, 1'b1, 1'b0, 1'b1, o_exec(1'b0, 2'b01, 1'b1),  1};
    tbl[8]  = '{1'b0, T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b1, o_fetch(1'b1),              2};
    tbl[9]  = '{1'b0, T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b1, O0,                         2};
    tbl[10] = '{1'b0, T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b1, o_exec(1'b0, 2'b01, 1'b0),  2};
    tbl[11] = '{1'b0, T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b0, o_fetch(1'b0),              3};
    tbl[12] = '{1'b0, T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b1, o_fetch(1'b1),              3};
    for (int i = 0; i < 13; i++)
      step(0, $sformatf("tbl%0d", i), tbl[i].r, tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].lt,
           tbl[i].rdy, tbl[i].eo, tbl[i].ei);

    // LOAD with two wait cycles in MEM
    step(0, "ld rst",    1'b1, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, O0, -1);
    step(0, "ld fetch",  1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, o_fetch(1'b1), 0);
    step(0, "ld dec",    1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, O0, 0);
    step(0, "ld exec",   1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, o_exec(1'b1, 2'b00, 1'b0), 0);
    step(0, "ld mem w1", 1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, o_mem(1'b0), 0);
    step(0, "ld mem w2", 1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, o_mem(1'b0), 0);
    step(0, "ld mem",    1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, o_mem(1'b0), 0);
    step(0, "ld wb",     1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b1, o_wb(2'b01), 0);
    step(0, "ld next",   1'b0, T_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, o_fetch(1'b0), 1);

    // LUI retires, then an illegal opcode traps with instret frozen until reset
    step(0, "tr rst",   1'b1, T_LUI, 3'd0, 1'b0, 1'b0, 1'b1, O0, -1);
    step(0, "tr fetch", 1'b0, T_LUI, 3'd0, 1'b0, 1'b0, 1'b1, o_fetch(1'b1), 0);
    step(0, "tr dec",   1'b0, T_LUI, 3'd0, 1'b0, 1'b0, 1'b1, O0, 0);
    step(0, "tr luiwb", 1'b0, T_LUI, 3'd0, 1'b0, 1'b0, 1'b1, o_wb(2'b10), 0);
    step(0, "tr fetch2",1'b0, T_ILL, 3'd0, 1'b0, 1'b0, 1'b1, o_fetch(1'b1), 1);
    step(0, "tr dec2",  1'b0, T_ILL, 3'd0, 1'b0, 1'b0, 1'b1, O0, 1);
    for (int i = 0; i < 3; i++)
      step(0, $sformatf("tr hold%0d", i), 1'b0, T_ILL, 3'd0, 1'b1, 1'b1, 1'b1, o_trap(), 1);
    step(0, "tr reset", 1'b1, T_ILL, 3'd0, 1'b0, 1'b0, 1'b0, O0, -1);
    step(0, "tr after", 1'b0, T_ILL, 3'd0, 1'b0, 1'b0, 1'b0, o_fetch(1'b0), 0);

    // Timeout of 4 while fetch is stalled
    step(1, "to rst", 1'b1, T_OP, 3'd0, 1'b0, 1'b0, 1'b0, O0, -1);
    for (int i = 0; i < 4; i++)
      step(1, $sformatf("to wait%0d", i), 1'b0, T_OP, 3'd0, 1'b0, 1'b0, 1'b0, o_fetch(1'b0), 0);
    step(1, "to trap",  1'b0, T_OP, 3'd0, 1'b0, 1'b0, 1'b1, o_trap(), 0);
    step(1, "to trap2", 1'b0, T_OP, 3'd0, 1'b0, 1'b0, 1'b1, o_trap(), 0);

    // Reset during the MEM phase of a STORE
    step(0, "st rst",   1'b1, T_LUI,   3'd0, 1'b0, 1'b0, 1'b1, O0, -1);
    step(0, "st f0",    1'b0, T_LUI,   3'd0, 1'b0, 1'b0, 1'b1, o_fetch(1'b1), 0);
    step(0, "st d0",    1'b0, T_LUI,   3'd0, 1'b0, 1'b0, 1'b1, O0, 0);
    step(0, "st wb0",   1'b0, T_LUI,   3'd0, 1'b0, 1'b0, 1'b1, o_wb(2'b10), 0);
    step(0, "st fetch", 1'b0, T_STORE, 3'd2, 1'b0, 1'b0, 1'b1, o_fetch(1'b1), 1);
    step(0, "st dec",   1'b0, T_STORE, 3'd2, 1'b0, 1'b0, 1'b1, O0, 1);
    step(0, "st exec",  1'b0, T_STORE, 3'd2, 1'b0, 1'b0, 1'b1, o_exec(1'b1, 2'b00, 1'b0), 1);
    step(0, "st mem",   1'b0, T_STORE, 3'd2, 1'b0, 1'b0, 1'b0, o_mem(1'b1), 1);
    step(0, "st abort", 1'b1, T_STORE, 3'd2, 1'b0, 1'b0, 1'b1, O0, -1);
    step(0, "st after", 1'b0, T_STORE, 3'd2, 1'b0, 1'b0, 1'b0, o_fetch(1'b0), 0);

    // Random run against the reference model, both timeout settings
    legal = '{T_LOAD, T_STORE, T_BRANCH, T_LUI, T_OPI, T_OP};
    need_op = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = (c == 0) || ($urandom_range(0, 99) < 2);
      drive(r,
            need_op ? (($urandom_range(0, 99) < 4) ? 7'($urandom) : legal[$urandom_range(0, 5)])
                    : opcode,
            need_op ? 3'($urandom) : funct3,
            1'($urandom), 1'($urandom), $urandom_range(0, 99) < 75);
      if (!reset) chk("rnd instret", a_inst, m_ret[0]);
      if (!reset) chk("rnd to instret", b_inst, m_ret[1]);
      model_cycle(0, 255, e, f);
      chk("rnd ctl", 32'(got0), 32'(e));
      model_cycle(1, 4, e, fdummy);
      chk("rnd to ctl", 32'(got1), 32'(e));
      need_op = f;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset datapath: PC, IR, register file, immediate generator, ALU, and a shared instruction/data memory port.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Owns the single memory handshake, drives all datapath write strobes and mux selects, and counts retired instructions.
- Supported opcodes: LOAD, STORE, BRANCH, LUI, OP-IMM, OP. Any other opcode traps.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles to wait for mem_ready before trapping; 0 disables the timeout.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed less-than flag from the ALU compare
- mem_ready  in  1  memory completes the transfer this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = read
- mem_ifetch  out  1  address mux: 1 = PC, 0 = ALU result
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = old_pc + imm
- reg_write  out  1  register-file write enable
- alu_src_imm  out  1  ALU operand B: 1 = imm, 0 = rs2
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct decode
- wb_sel  out  2  00 = ALU, 01 = mem data, 10 = imm
- trap  out  1  sticky: illegal opcode or memory timeout
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset:
  - state = FETCH; all outputs 0; instret = 0; trap = 0; timeout counter = 0.
  - Reset asserted mid-instruction aborts it. No strobe is asserted in any cycle where reset is high.
- Outputs are combinational from state plus inputs (Mealy). Unlisted outputs are 0 in each state.
- Transfer rule: a memory transfer completes in the cycle where mem_req && mem_ready. mem_req stays high and its qualifiers stay stable until then.
- FETCH:
  - mem_req = 1, mem_ifetch = 1.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0; go to DECODE.
- DECODE (1 cycle, no strobes):
  - LUI → WB.
  - LOAD, STORE, OP-IMM, OP, BRANCH → EXEC.
  - Other opcode → TRAP.
- EXEC:
  - LOAD/STORE: alu_src_imm = 1, alu_op = 00; go to MEM.
  - OP-IMM: alu_src_imm = 1, alu_op = 10; go to WB.
  - OP: alu_src_imm = 0, alu_op = 10; go to WB.
  - BRANCH: alu_op = 01.
    - taken = BEQ: zero; BNE: !zero; BLT: lt; BGE: !lt. funct3 010/011/110/111 → not taken.
    - If taken: pc_write = 1, pc_src = 1.
    - Retire; go to FETCH.
- MEM:
  - mem_req = 1, mem_ifetch = 0, mem_we = (opcode == STORE).
  - On mem_ready: STORE retires and goes to FETCH; LOAD goes to WB.
- WB:
  - reg_write = 1.
  - wb_sel: LOAD = 01, LUI = 10, otherwise 00.
  - Retire; go to FETCH.
- Retire: instret increments by 1, wrapping modulo 2^INSTRET_W.
- Latency with zero-wait memory (cycles):
  - BRANCH 3, LUI 3, OP/OP-IMM 4, STORE 4, LOAD 5.
  - Each memory wait cycle adds 1.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_req && !mem_ready.
  - If it reaches TIMEOUT_CYCLES (when nonzero) → TRAP; the same cycle does not complete a transfer.
- TRAP: trap = 1, all strobes 0, and instret holds. The only exit is reset.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode constants
  - alu_op and wb_sel encodings
  - funct3 branch constants
- Optional combinational sub-module branch_cond (funct3, alu_zero, alu_lt → taken), reusable by a later pipelined core.

Test Plan:
- OP-IMM with mem_ready tied 1 → FETCH, DECODE, EXEC, WB over 4 cycles; reg_write = 1 only in cycle 4 with wb_sel = 00; instret 0 → 1.
- LOAD with mem_ready low for 2 cycles in MEM → 7 cycles total; one reg_write with wb_sel = 01; mem_we = 0 throughout MEM.
- BEQ with alu_zero = 1, then BNE with alu_zero = 1 → first has pc_write = 1 and pc_src = 1 in EXEC; second has no EXEC pc_write; each takes 3 cycles and instret increments for both.
- Opcode 7'b1110011 → TRAP after DECODE; trap = 1 and stays; no strobes afterward; instret frozen; reset returns to FETCH with trap = 0.
- TIMEOUT_CYCLES = 4, mem_ready stuck 0 in FETCH → trap asserts after 4 wait cycles; ir_write never asserted.
- Reset asserted during MEM of a STORE → no mem_req in the reset cycle; next cycle in FETCH with instret = 0.
